// File: rtl/ball_tree_controller.sv
// Ball-split controller: heap-ordered tree of ball slots; rope hits split a ball
// into its two children or pop the smallest size, and the unit reports when wiped out.
module ball_tree_controller #(
  parameter int LEVELS = 4,
  parameter int NBALLS = (1 << LEVELS) - 1,
  parameter int SW     = ($clog2(LEVELS) < 1) ? 1 : $clog2(LEVELS),
  parameter int IW     = $clog2(NBALLS),
  parameter int CW     = $clog2(NBALLS + 1)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              unitActive,
  input  logic [SW-1:0]     initialSize,
  input  logic [NBALLS-1:0] col_rope,
  input  logic [NBALLS-1:0] col_player,
  output logic [NBALLS-1:0] visible,
  output logic [NBALLS-1:0] ballReset,
  output logic              ropeHit,
  output logic [SW-1:0]     hitType,
  output logic [IW-1:0]     hitIndex,
  output logic              playerHit,
  output logic [CW-1:0]     ballsLeft,
  output logic              inUse,
  output logic              cleared
);

  typedef enum logic [1:0] {IDLE, DEPLOY, ACTIVE, CLEARED} state_t;

  state_t            r_state, w_state_nxt;
  logic [NBALLS-1:0] r_visible, r_ballReset;
  logic              r_ropeHit, r_playerHit, r_inUse, r_cleared;
  logic [SW-1:0]     r_hitType;
  logic [IW-1:0]     r_hitIndex;
  logic [CW-1:0]     r_ballsLeft;

  logic [NBALLS-1:0] w_visible_nxt, w_ballReset_nxt, w_cand, w_children;
  logic              w_ropeHit_nxt, w_playerHit_nxt, w_inUse_nxt, w_cleared_nxt;
  logic [SW-1:0]     w_hitType_nxt, w_hitSize;
  logic [IW-1:0]     w_hitIndex_nxt, w_k;
  logic [CW-1:0]     w_ballsLeft_nxt;
  logic              w_hit;

  // Size of a slot: the root is the largest ball, each tree level one size smaller.
  function automatic logic [SW-1:0] size_of(input int idx);
    int lvl;
    lvl = 0;
    for (int l = 0; l < LEVELS; l++)
      if (idx + 1 >= (1 << l)) lvl = l;
    return SW'(LEVELS - 1 - lvl);
  endfunction

  // First slot of the level holding balls of the requested (clamped) size.
  function automatic logic [IW-1:0] start_slot(input logic [SW-1:0] sz);
    int s;
    s = int'(sz);
    if (s > LEVELS - 1) s = LEVELS - 1;
    return IW'((1 << (LEVELS - 1 - s)) - 1);
  endfunction

  // Lowest-index visible rope collision wins; the rest are dropped this cycle.
  always_comb begin
    w_cand = col_rope & r_visible;
    w_hit  = 1'b0;
    w_k    = '0;
    for (int i = NBALLS - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_hit = 1'b1;
        w_k   = IW'(i);
      end
    end
    w_hitSize  = size_of(int'(w_k));
    w_children = NBALLS'(3) << (2 * int'(w_k) + 1);
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_visible_nxt   = r_visible;
    w_ballReset_nxt = '0;
    w_ropeHit_nxt   = 1'b0;
    w_hitType_nxt   = r_hitType;
    w_hitIndex_nxt  = r_hitIndex;
    w_playerHit_nxt = 1'b0;
    w_ballsLeft_nxt = r_ballsLeft;
    w_inUse_nxt     = r_inUse;
    w_cleared_nxt   = 1'b0;
    if (!unitActive) begin
      w_state_nxt     = IDLE;
      w_visible_nxt   = '0;
      w_hitType_nxt   = '0;
      w_hitIndex_nxt  = '0;
      w_ballsLeft_nxt = '0;
      w_inUse_nxt     = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt     = DEPLOY;
          w_visible_nxt   = '0;
          w_ballsLeft_nxt = '0;
          w_inUse_nxt     = 1'b0;
        end
        DEPLOY: begin
          w_state_nxt     = ACTIVE;
          w_visible_nxt   = NBALLS'(1) << start_slot(initialSize);
          w_ballReset_nxt = NBALLS'(1) << start_slot(initialSize);
          w_ballsLeft_nxt = CW'(1);
          w_inUse_nxt     = 1'b1;
        end
        ACTIVE: begin
          w_playerHit_nxt = |(col_player & r_visible);
          if (w_hit) begin
            w_visible_nxt  = r_visible & ~(NBALLS'(1) << w_k);
            w_ropeHit_nxt  = 1'b1;
            w_hitType_nxt  = w_hitSize;
            w_hitIndex_nxt = w_k;
            if (w_hitSize != '0) begin
              w_visible_nxt   = w_visible_nxt | w_children;
              w_ballReset_nxt = w_children;
              w_ballsLeft_nxt = r_ballsLeft + CW'(1);
            end else begin
              w_ballsLeft_nxt = r_ballsLeft - CW'(1);
              if (r_ballsLeft == CW'(1)) begin
                w_cleared_nxt = 1'b1;
                w_inUse_nxt   = 1'b0;
                w_state_nxt   = CLEARED;
              end
            end
          end
        end
        CLEARED: begin
          w_visible_nxt   = '0;
          w_ballsLeft_nxt = '0;
          w_inUse_nxt     = 1'b0;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= IDLE;
      r_visible   <= '0;
      r_ballReset <= '0;
      r_ropeHit   <= 1'b0;
      r_hitType   <= '0;
      r_hitIndex  <= '0;
      r_playerHit <= 1'b0;
      r_ballsLeft <= '0;
      r_inUse     <= 1'b0;
      r_cleared   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_visible   <= w_visible_nxt;
      r_ballReset <= w_ballReset_nxt;
      r_ropeHit   <= w_ropeHit_nxt;
      r_hitType   <= w_hitType_nxt;
      r_hitIndex  <= w_hitIndex_nxt;
      r_playerHit <= w_playerHit_nxt;
      r_ballsLeft <= w_ballsLeft_nxt;
      r_inUse     <= w_inUse_nxt;
      r_cleared   <= w_cleared_nxt;
    end
  end

  assign visible   = r_visible;
  assign ballReset = r_ballReset;
  assign ropeHit   = r_ropeHit;
  assign hitType   = r_hitType;
  assign hitIndex  = r_hitIndex;
  assign playerHit = r_playerHit;
  assign ballsLeft = r_ballsLeft;
  assign inUse     = r_inUse;
  assign cleared   = r_cleared;

endmodule

// File: tb/tb_ball_tree_controller.sv
// Directed vector bench for ball_tree_controller with LEVELS=4 (15 slots).
module tb_ball_tree_controller;

  localparam int LEVELS = 4;
  localparam int NB     = 15;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          unitActive = 1'b0;
  logic [1:0]    initialSize = 2'd3;
  logic [NB-1:0] col_rope = '0;
  logic [NB-1:0] col_player = '0;
  logic [NB-1:0] visible, ballReset;
  logic          ropeHit, playerHit, inUse, cleared;
  logic [1:0]    hitType;
  logic [3:0]    hitIndex, ballsLeft;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic          ua;
    logic [1:0]    isz;
    logic [NB-1:0] rope, ply;
    logic [NB-1:0] vis, brst;
    logic          rh;
    logic [1:0]    ht;
    logic [3:0]    hi;
    logic          ph;
    logic [3:0]    bl;
    logic          iu, cl;
  } vec_t;

  vec_t tbl[$];

  ball_tree_controller #(.LEVELS(LEVELS)) dut (
    .clk(clk), .resetN(resetN), .unitActive(unitActive), .initialSize(initialSize),
    .col_rope(col_rope), .col_player(col_player), .visible(visible),
    .ballReset(ballReset), .ropeHit(ropeHit), .hitType(hitType), .hitIndex(hitIndex),
    .playerHit(playerHit), .ballsLeft(ballsLeft), .inUse(inUse), .cleared(cleared)
  );

  always #5 clk = ~clk;

  task automatic add(input logic ua, input logic [1:0] isz, input logic [NB-1:0] rope,
                     input logic [NB-1:0] ply, input logic [NB-1:0] vis,
                     input logic [NB-1:0] brst, input logic rh, input logic [1:0] ht,
                     input logic [3:0] hi, input logic ph, input logic [3:0] bl,
                     input logic iu, input logic cl);
    vec_t v;
    v.ua = ua; v.isz = isz; v.rope = rope; v.ply = ply; v.vis = vis; v.brst = brst;
    v.rh = rh; v.ht = ht; v.hi = hi; v.ph = ph; v.bl = bl; v.iu = iu; v.cl = cl;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input vec_t e);
    n_vec++;
    if (visible !== e.vis || ballReset !== e.brst || ropeHit !== e.rh ||
        hitType !== e.ht || hitIndex !== e.hi || playerHit !== e.ph ||
        ballsLeft !== e.bl || inUse !== e.iu || cleared !== e.cl) begin
      n_bad++;
      $display("FAIL %s: got vis=%h rst=%h rh=%b ht=%0d hi=%0d ph=%b bl=%0d iu=%b cl=%b | want vis=%h rst=%h rh=%b ht=%0d hi=%0d ph=%b bl=%0d iu=%b cl=%b",
               nm, visible, ballReset, ropeHit, hitType, hitIndex, playerHit, ballsLeft, inUse, cleared,
               e.vis, e.brst, e.rh, e.ht, e.hi, e.ph, e.bl, e.iu, e.cl);
    end
  endtask

  function automatic vec_t outs(input logic [NB-1:0] vis, input logic [NB-1:0] brst,
                                input logic rh, input logic [1:0] ht, input logic [3:0] hi,
                                input logic ph, input logic [3:0] bl, input logic iu,
                                input logic cl);
    vec_t v;
    v.ua = 1'b0; v.isz = '0; v.rope = '0; v.ply = '0;
    v.vis = vis; v.brst = brst; v.rh = rh; v.ht = ht; v.hi = hi;
    v.ph = ph; v.bl = bl; v.iu = iu; v.cl = cl;
    return v;
  endfunction

  task automatic step(input logic ua, input logic [1:0] isz,
                      input logic [NB-1:0] rope, input logic [NB-1:0] ply);
    @(negedge clk);
    unitActive = ua; initialSize = isz; col_rope = rope; col_player = ply;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   ua isz rope     ply      vis      brst     rh ht hi ph bl iu cl
    add(0, 3, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0, 0, 0, 0, 0, 0, 0); // idle
    add(1, 3, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0, 0, 0, 0, 0, 0, 0); // -> deploy
    add(1, 3, 15'h0000, 15'h0000, 15'h0001, 15'h0001, 0, 0, 0, 0, 1, 1, 0); // root out
    add(1, 3, 15'h0000, 15'h0000, 15'h0001, 15'h0000, 0, 0, 0, 0, 1, 1, 0); // pulse ends
    add(1, 3, 15'h0001, 15'h0000, 15'h0006, 15'h0006, 1, 3, 0, 0, 2, 1, 0); // split root
    add(1, 3, 15'h0006, 15'h0002, 15'h001C, 15'h0018, 1, 2, 1, 1, 3, 1, 0); // 1 wins over 2
    add(1, 3, 15'h0020, 15'h0000, 15'h001C, 15'h0000, 0, 2, 1, 0, 3, 1, 0); // ghost hit
    add(1, 3, 15'h0000, 15'h0004, 15'h001C, 15'h0000, 0, 2, 1, 1, 3, 1, 0); // player hit
    add(1, 3, 15'h0008, 15'h0002, 15'h0194, 15'h0180, 1, 1, 3, 0, 4, 1, 0); // split slot 3
    add(1, 3, 15'h0080, 15'h0000, 15'h0114, 15'h0000, 1, 0, 7, 0, 3, 1, 0); // pop leaf 7
    add(0, 3, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0, 0, 0, 0, 0, 0, 0); // abort
    add(1, 0, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0, 0, 0, 0, 0, 0, 0); // -> deploy
    add(1, 0, 15'h0000, 15'h0000, 15'h0080, 15'h0080, 0, 0, 0, 0, 1, 1, 0); // smallest start
    add(1, 0, 15'h0080, 15'h0000, 15'h0000, 15'h0000, 1, 0, 7, 0, 0, 0, 1); // wiped out
    add(1, 0, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0, 0, 7, 0, 0, 0, 0); // cleared drops
    add(1, 0, 15'h0080, 15'h7FFF, 15'h0000, 15'h0000, 0, 0, 7, 0, 0, 0, 0); // stuck cleared
    add(0, 0, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0, 0, 0, 0, 0, 0, 0); // back to idle
    add(1, 1, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 0, 0, 0, 0, 0, 0, 0); // -> deploy
    add(1, 1, 15'h0000, 15'h0000, 15'h0008, 15'h0008, 0, 0, 0, 0, 1, 1, 0); // size 1 start
    add(1, 1, 15'h0008, 15'h0000, 15'h0180, 15'h0180, 1, 1, 3, 0, 2, 1, 0); // split 3

    #1;
    chk("reset", outs(15'h0, 15'h0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    resetN = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].ua, tbl[i].isz, tbl[i].rope, tbl[i].ply);
      chk($sformatf("vec%0d", i), tbl[i]);
    end

    // Pop slot 7, then drop resetN between clock edges.
    step(1'b1, 2'd1, 15'h0080, 15'h0000);
    chk("pop7", outs(15'h0100, 15'h0, 1, 0, 7, 0, 1, 1, 0));
    #1 resetN = 1'b0;
    #1;
    chk("async_rst", outs(15'h0, 15'h0, 0, 0, 0, 0, 0, 0, 0));
    step(1'b1, 2'd3, 15'h0100, 15'h0100);
    chk("rst_held", outs(15'h0, 15'h0, 0, 0, 0, 0, 0, 0, 0));
    resetN = 1'b1;
    step(1'b1, 2'd3, 15'h0000, 15'h0000);
    chk("redeploy1", outs(15'h0, 15'h0, 0, 0, 0, 0, 0, 0, 0));
    step(1'b1, 2'd3, 15'h0000, 15'h0000);
    chk("redeploy2", outs(15'h0001, 15'h0001, 0, 0, 0, 0, 1, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ball_tree_controller.md
Name: ball_tree_controller

Overview:
- Parametrised ball-split controller for the ball subsystem.
- Manages a binary tree of NBALLS = 2^LEVELS-1 ball slots in heap order: slot 0 is the largest ball, and the children of slot i are 2i+1 and 2i+2.
- A rope hit on a visible ball hides it and spawns its two children. A rope hit on a smallest-size ball removes it.
- Tracks live-ball count and raises a one-cycle cleared pulse when the unit is wiped out. Sits between the per-ball movement/collision units and the game/score logic.

Parameters:
- LEVELS, 4, number of ball sizes (2..5); NBALLS = 2^LEVELS-1
- SW, $clog2(LEVELS) (min 1), width of size/type fields
- IW, $clog2(NBALLS), width of slot index
- CW, $clog2(NBALLS+1), width of live-ball counter

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- unitActive  in  1  level; 1 = unit enabled, 0 = unit cleared and idle
- initialSize  in  SW  size of the starting ball (0 = smallest, LEVELS-1 = largest)
- col_rope  in  NBALLS  per-slot rope collision
- col_player  in  NBALLS  per-slot player collision
- visible  out  NBALLS  per-slot visible flag (registered)
- ballReset  out  NBALLS  per-slot one-cycle spawn pulse (registered)
- ropeHit  out  1  one-cycle pulse: a ball was split or popped
- hitType  out  SW  size of the hit ball; valid with ropeHit
- hitIndex  out  IW  slot of the hit ball; valid with ropeHit
- playerHit  out  1  registered OR of (col_player & visible)
- ballsLeft  out  CW  number of visible balls
- inUse  out  1  1 in DEPLOY/ACTIVE
- cleared  out  1  one-cycle pulse when ballsLeft reaches 0 from a hit

Behaviour:
- Reset: every output is 0, and the state is IDLE.
- Slot size definitions:
  - Level of slot i = floor(log2(i+1)).
  - size(i) = LEVELS-1-level(i).
  - The start slot is 2^(LEVELS-1-s)-1, where s = min(initialSize, LEVELS-1). initialSize is sampled in DEPLOY.
- States: IDLE, DEPLOY, ACTIVE, CLEARED.
- Global rule: on any edge with unitActive=0, next state is IDLE. On that same edge visible, ballReset, ballsLeft, ropeHit, playerHit, inUse and cleared are all 0. This has priority over every other rule and applies mid-operation.
- IDLE: unitActive=1 -> DEPLOY; outputs stay 0.
- DEPLOY (exactly 1 cycle):
  - visible[start]<=1, ballReset[start]<=1, ballsLeft<=1, inUse<=1.
  - Next state is ACTIVE.
  - Total latency from unitActive rise to visible: 2 edges.
- ACTIVE:
  - ballReset defaults to 0 every cycle, so it is a strict one-cycle pulse.
  - Candidate set = col_rope & visible; collisions on invisible slots are ignored.
  - At most one hit per cycle: the lowest-index candidate k wins. Other candidates are dropped, not queued.
  - On hit k, in one edge: visible[k]<=0; ropeHit<=1; hitType<=size(k); hitIndex<=k.
  - If size(k)>0: visible and ballReset of 2k+1 and 2k+2 <=1, and ballsLeft<=ballsLeft+1.
  - Else: ballsLeft<=ballsLeft-1.
  - If ballsLeft-1 reaches 0: cleared<=1, inUse<=0, next state is CLEARED.
  - No hit: ropeHit<=0, and hitType/hitIndex hold their values.
- CLEARED:
  - cleared returns to 0 after 1 cycle; all visible=0.
  - Stays in CLEARED until unitActive=0 -> IDLE. Re-arming requires unitActive to go low then high.
- playerHit: registered every cycle in ACTIVE, 1-cycle latency. It is 0 in all other states and is independent of rope arbitration.
- Counter: ballsLeft never exceeds NBALLS-(NBALLS-1)/2 and never underflows, because a decrement happens only on a visible leaf.

Test Plan:
- LEVELS=4, initialSize=3, unitActive 0->1 -> after 2 edges visible=0x0001, ballReset=0x0001 for 1 cycle only, inUse=1, ballsLeft=1.
- From that state, col_rope[0] for 1 cycle -> next edge visible=0x0006, ballReset=0x0006 pulse, ropeHit=1, hitType=3, hitIndex=0, ballsLeft=2.
- Simultaneous hits: with visible=0x0006, col_rope=0x0006 -> only slot 1 splits: visible=0x001C, hitIndex=1; slot 2 is unaffected that cycle.
- initialSize=0 -> start slot 7 (visible=0x0080); col_rope[7] -> visible=0, ballsLeft=0, ropeHit=1, hitType=0, cleared=1 for 1 cycle, inUse=0, state CLEARED.
- Ghost and player hits: col_rope[5]=1 while visible[5]=0 -> no change, ropeHit=0. col_player[1]=1 with visible[1]=1 -> playerHit=1 one cycle later.
- Mid-operation abort: unitActive=0 while visible=0x001C -> next edge all outputs 0, state IDLE. unitActive=1 again redeploys normally. Async resetN low mid-split clears all outputs immediately.
